// File: rtl/od_isp_skid_rx.sv
// od_isp_skid_rx: 2-entry skid FIFO from opcode decoder to issue stage,
// re-encoding one-hot opcode fields to binary and flagging inconsistent decodes.
module od_isp_skid_rx #(
    parameter int BUS_W    = 148,
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                od_valid_i,
    output logic                od_allowin_o,
    input  logic [BUS_W-1:0]    od_bus_i,
    output logic                isp_valid_o,
    input  logic                isp_allowin_i,
    output logic [BUS_W-1:0]    isp_bus_o,
    output logic [5:0]          op31_26_o,
    output logic [3:0]          op25_22_o,
    output logic [1:0]          op21_20_o,
    output logic [4:0]          op19_15_o,
    output logic                dec_err_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);
    localparam int EW = BUS_W + 18;

    // {bad, index}; index forced to 0 unless exactly one bit is set
    function automatic logic [6:0] enc(input logic [63:0] v);
        logic [5:0] idx;
        logic [6:0] n;
        idx = '0;
        n   = '0;
        for (int i = 0; i < 64; i++)
            if (v[i]) begin
                idx = i[5:0];
                n   = n + 7'd1;
            end
        return (n == 7'd1) ? {1'b0, idx} : {1'b1, 6'd0};
    endfunction

    logic [EW-1:0]       mem_q [2];
    logic [EW-1:0]       mem_d [2];
    logic [EW-1:0]       head_q, head_d, new_entry;
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d, rd_q, rd_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [6:0]          e31, e25, e21, e19;
    logic                new_err, push, pop;

    assign od_allowin_o = (cnt_q != DEPTH[1:0]);
    assign isp_valid_o  = (cnt_q != 2'd0);
    assign push         = od_valid_i & od_allowin_o & ~flush_i;
    assign pop          = isp_valid_o & isp_allowin_i & ~flush_i;

    always_comb begin
        e31 = enc(od_bus_i[147:84]);
        e25 = enc({48'd0, od_bus_i[83:68]});
        e21 = enc({60'd0, od_bus_i[67:64]});
        e19 = enc({32'd0, od_bus_i[63:32]});
        new_err = e31[6] | e25[6] | e21[6] | e19[6]
                | (e31[5:0] != od_bus_i[31:26])
                | (e25[5:0] != {2'b0, od_bus_i[25:22]})
                | (e21[5:0] != {4'b0, od_bus_i[21:20]})
                | (e19[5:0] != {1'b0, od_bus_i[19:15]});
        new_entry = {od_bus_i, e31[5:0], e25[3:0], e21[1:0], e19[4:0], new_err};
        mem_d = mem_q;
        if (push) mem_d[wr_q] = new_entry;
        cnt_d = flush_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        wr_d  = ~flush_i & (wr_q ^ push);
        rd_d  = ~flush_i & (rd_q ^ pop);
        // output register tracks the next head, holding its last value when empty
        head_d    = (cnt_d != 2'd0) ? mem_d[rd_d] : head_q;
        err_cnt_d = (push && new_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            head_q    <= '0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            mem_q     <= mem_d;
            head_q    <= head_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign {isp_bus_o, op31_26_o, op25_22_o, op21_20_o, op19_15_o, dec_err_o} = head_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_od_isp_skid_rx.sv
// tb_od_isp_skid_rx: directed stimulus with a queue-based reference model of the skid FIFO.
module tb_od_isp_skid_rx;
    logic         clk = 1'b0, rst_n = 1'b1, flush = 1'b0, od_valid = 1'b0, isp_allowin = 1'b0;
    logic [147:0] od_bus = '0;
    logic         od_allowin_o, isp_valid_o, dec_err_o;
    logic [147:0] isp_bus_o;
    logic [5:0]   op31_26_o;
    logic [3:0]   op25_22_o;
    logic [1:0]   op21_20_o;
    logic [4:0]   op19_15_o;
    logic [7:0]   err_cnt_o;
    int           errors = 0, checks = 0;
    bit           run = 0;

    od_isp_skid_rx dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .od_valid_i(od_valid),
        .od_allowin_o(od_allowin_o), .od_bus_i(od_bus), .isp_valid_o(isp_valid_o),
        .isp_allowin_i(isp_allowin), .isp_bus_o(isp_bus_o), .op31_26_o(op31_26_o),
        .op25_22_o(op25_22_o), .op21_20_o(op21_20_o), .op19_15_o(op19_15_o),
        .dec_err_o(dec_err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] renc(input logic [63:0] v);
        return ($countones(v) == 1) ? 6'($clog2(v)) : 6'd0;
    endfunction

    function automatic logic rerr(input logic [147:0] b);
        logic [31:0] i = b[31:0];
        return $countones(b[147:84]) != 1 || $countones(b[83:68]) != 1
            || $countones(b[67:64]) != 1 || $countones(b[63:32]) != 1
            || renc(b[147:84]) != i[31:26] || renc({48'd0, b[83:68]}) != 6'(i[25:22])
            || renc({60'd0, b[67:64]}) != 6'(i[21:20]) || renc({32'd0, b[63:32]}) != 6'(i[19:15]);
    endfunction

    function automatic logic [147:0] mk(input logic [31:0] i);
        logic [63:0] a = 64'd1 << i[31:26];
        logic [15:0] b = 16'd1 << i[25:22];
        logic [3:0]  c = 4'd1 << i[21:20];
        logic [31:0] d = 32'd1 << i[19:15];
        return {a, b, c, d, i};
    endfunction

    logic [147:0] q[$];
    logic [147:0] hold;
    logic [7:0]   ecnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            hold = '0;
            ecnt = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            automatic bit do_push = od_valid && q.size() < 2;
            if (q.size() > 0 && isp_allowin) void'(q.pop_front());
            if (do_push) begin
                q.push_back(od_bus);
                if (rerr(od_bus) && ecnt != 8'hFF) ecnt = ecnt + 8'd1;
            end
            if (q.size() > 0) hold = q[0];
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("isp_valid", isp_valid_o, q.size() != 0);
            chk("od_allowin", od_allowin_o, q.size() < 2);
            chk("err_cnt", err_cnt_o, ecnt);
            chk("isp_bus", isp_bus_o, hold);
            chk("op31_26", op31_26_o, renc(hold[147:84]));
            chk("op25_22", op25_22_o, renc({48'd0, hold[83:68]}));
            chk("op21_20", op21_20_o, renc({60'd0, hold[67:64]}));
            chk("op19_15", op19_15_o, renc({32'd0, hold[63:32]}));
            if (q.size() != 0) chk("dec_err", dec_err_o, rerr(hold));
        end
    end

    task automatic send(input logic [147:0] w);
        od_bus   = w;
        od_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (od_allowin_o) begin
                @(negedge clk);
                od_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: od_allowin_o stayed %b, required 1", od_allowin_o);
        od_valid = 1'b0;
    endtask

    logic [147:0] wa, wb, wc, w4;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", isp_valid_o, 0);
        chk("rst_errcnt", err_cnt_o, 0);
        chk("rst_bus", isp_bus_o, 0);
        chk("rst_dec_err", dec_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1;
        chk("rst_allowin", od_allowin_o, 1);
        // 1: single consistent word
        isp_allowin = 1'b1;
        send(mk(32'h02800421));
        chk("t1_valid", isp_valid_o, 1);
        chk("t1_op31_26", op31_26_o, 6'h00);
        chk("t1_op25_22", op25_22_o, 4'hA);
        chk("t1_op21_20", op21_20_o, 2'd0);
        chk("t1_op19_15", op19_15_o, 5'h00);
        chk("t1_dec_err", dec_err_o, 0);
        repeat (2) @(negedge clk);
        // 2/3: fill, stall upstream, then drain with overlapping push and pop
        wa = mk(32'h1C4A8F00);
        wb = mk(32'hFFFFFFFF);
        wc = mk(32'h0C712345);
        isp_allowin = 1'b0;
        send(wa);
        send(wb);
        chk("t2_full_allowin", od_allowin_o, 0);
        chk("t2_head_a", isp_bus_o, wa);
        fork
            send(wc);
            begin
                repeat (2) @(negedge clk);
                isp_allowin = 1'b1;
            end
        join
        for (int i = 0; i < 6; i++) send(mk(32'h13579BDF + i * 32'h01234567));
        repeat (3) @(negedge clk);
        // 4: d21_20 decodes inst[1:0] instead of inst[21:20]
        w4 = mk(32'h00100003);
        w4[67:64] = 4'b1000;
        send(w4);
        chk("t4_dec_err", dec_err_o, 1);
        chk("t4_err_cnt", err_cnt_o, 8'd1);
        // 5: zero and double-bit d19_15, then saturation
        w4 = mk(32'h00000000);
        w4[63:32] = '0;
        send(w4);
        chk("t5_zero_err", dec_err_o, 1);
        chk("t5_zero_op", op19_15_o, 5'd0);
        w4[63:32] = 32'h0000_0005;
        send(w4);
        chk("t5_two_err", dec_err_o, 1);
        chk("t5_two_op", op19_15_o, 5'd0);
        chk("t5_err_cnt3", err_cnt_o, 8'd3);
        for (int i = 0; i < 300; i++) send(w4);
        repeat (2) @(negedge clk);
        chk("t5_saturate", err_cnt_o, 8'hFF);
        // 6: flush with two entries held and a word offered
        isp_allowin = 1'b0;
        send(wa);
        send(wb);
        chk("t6_pre_valid", isp_valid_o, 1);
        od_bus   = wc;
        od_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        od_valid = 1'b0;
        chk("t6_valid", isp_valid_o, 0);
        chk("t6_allowin", od_allowin_o, 1);
        chk("t6_err_cnt", err_cnt_o, 8'hFF);
        send(wc);
        chk("t6_after_flush", isp_bus_o, wc);
        // reset mid-stream
        od_bus   = wb;
        od_valid = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst2_valid", isp_valid_o, 0);
        chk("rst2_errcnt", err_cnt_o, 0);
        chk("rst2_bus", isp_bus_o, 0);
        chk("rst2_op25_22", op25_22_o, 0);
        od_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        isp_allowin = 1'b1;
        send(mk(32'h02800421));
        chk("rst2_resume", op25_22_o, 4'hA);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
